// File: rtl/double_tokens_if.sv
// Token stream bundle for double_tokens: one input token line, the emitted
// token line, the sticky saturation flag and the owed-token count.
// Tokens are single-cycle pulses: a==1 in a sampled cycle is one token in,
// b==1 in a cycle is one token out. There is no back-pressure.
interface double_tokens_if #(
  parameter int MAX_PENDING = 255
) ();
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          a;
  logic          b;
  logic          overflow;
  logic [PW-1:0] pending;

  // Token source side
  modport master (
    output a,
    input  b,
    input  overflow,
    input  pending
  );

  // Token multiplier side
  modport slave (
    input  a,
    output b,
    output overflow,
    output pending
  );
endinterface

// File: rtl/double_tokens.sv
// Token multiplier: every input token on a is turned into MULT output
// tokens on b. The first output token leaves combinationally in the same
// cycle as the input token; the rest are owed in a saturating counter and
// drained one per cycle. If the owed count would exceed MAX_PENDING the
// excess is discarded and a sticky overflow flag is raised until reset.
module double_tokens #(
  parameter int MULT        = 2,
  parameter int MAX_PENDING = 255
) (
  input  logic               clk,
  input  logic               rst,
  double_tokens_if.slave     bus
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int NW = PW + 4;

  localparam logic [NW-1:0] MULT_W = NW'(MULT);
  localparam logic [NW-1:0] MAX_W  = NW'(MAX_PENDING);
  localparam logic [PW-1:0] MAX_P  = PW'(MAX_PENDING);

  logic [PW-1:0] pending_q;
  logic [PW-1:0] pending_d;
  logic          overflow_q;
  logic          overflow_d;
  logic          b_w;
  logic [NW-1:0] next_w;

  // Emit a token whenever one arrives or one is owed; silent while in reset
  always_comb begin
    b_w = rst & (bus.a | (pending_q != '0));
  end

  // Owed-count update, evaluated wide so the saturation test cannot wrap.
  // b==1 implies a==1 or pending>0, so the subtraction never underflows.
  always_comb begin
    next_w     = {4'b0000, pending_q}
               + (bus.a ? MULT_W : '0)
               - {{(NW-1){1'b0}}, b_w};
    pending_d  = next_w[PW-1:0];
    overflow_d = overflow_q;
    if (next_w > MAX_W) begin
      pending_d  = MAX_P;
      overflow_d = 1'b1;
    end
  end

  // Owed-count and sticky overflow registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.b        = b_w;
  assign bus.overflow = overflow_q;
  assign bus.pending  = pending_q;
endmodule

// File: tb/tb_double_tokens.sv
module tb_double_tokens;
  localparam int MAXP = 255;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int W    = PW + 2;  // {b, overflow, pending}

  logic clk;
  logic rst;

  double_tokens_if #(.MAX_PENDING(MAXP)) if2 ();
  double_tokens_if #(.MAX_PENDING(MAXP)) if3 ();

  double_tokens #(.MULT(2), .MAX_PENDING(MAXP)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  double_tokens #(.MULT(3), .MAX_PENDING(MAXP)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  // ---------------- clock / timeout ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] exp3_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitors: one expected entry per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp2_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp2_q.pop_front();
      check("dut2 {b,ovf,pend}", {22'd0, if2.b, if2.overflow, if2.pending}, {22'd0, e});
    end
  end

  always @(negedge clk) begin
    if (exp3_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp3_q.pop_front();
      check("dut3 {b,ovf,pend}", {22'd0, if3.b, if3.overflow, if3.pending}, {22'd0, e});
    end
  end

  // Token counter for the conservation check
  logic cnt_en = 1'b0;
  int   b_cnt  = 0;
  always @(negedge clk) begin
    if (cnt_en && if2.b) b_cnt++;
  end

  // ---------------- reference model for MULT=2 ----------------
  int   m2_pend = 0;
  logic m2_ovf  = 1'b0;
  int   a_cnt   = 0;

  task automatic model_reset();
    m2_pend = 0;
    m2_ovf  = 1'b0;
  endtask

  // Drive a for the current cycle and push what the DUT must show in it
  task automatic drive2(input logic av);
    logic be;
    int   nxt;
    if2.a = av;
    if (av) a_cnt++;
    be = av | (m2_pend != 0);
    exp2_q.push_back({be, m2_ovf, PW'(m2_pend)});
    nxt = m2_pend + (av ? 2 : 0) - (be ? 1 : 0);
    if (nxt > MAXP) begin
      m2_pend = MAXP;
      m2_ovf  = 1'b1;
    end else begin
      m2_pend = nxt;
    end
  endtask

  task automatic step2(input logic av);
    @(posedge clk);
    #1;
    drive2(av);
  endtask

  // Directed drivers with hand-computed expectations
  task automatic dir2(input logic av, input logic be, input logic [PW-1:0] pe);
    @(posedge clk);
    #1;
    if2.a = av;
    exp2_q.push_back({be, 1'b0, pe});
  endtask

  task automatic dir3(input logic av, input logic be, input logic [PW-1:0] pe);
    @(posedge clk);
    #1;
    if3.a = av;
    exp3_q.push_back({be, 1'b0, pe});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b0;
    if2.a  = 1'b0;
    if3.a  = 1'b0;

    // Reset state, including b held low while a is high
    #12;
    if2.a = 1'b1;
    if3.a = 1'b1;
    #1;
    check("reset dut2 b/ovf/pend", {22'd0, if2.b, if2.overflow, if2.pending}, 32'd0);
    check("reset dut3 b/ovf/pend", {22'd0, if3.b, if3.overflow, if3.pending}, 32'd0);
    if2.a = 1'b0;
    if3.a = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Single token: b on cycles 0,1; pending 1 then 0
    dir2(1'b1, 1'b1, 8'd0);
    dir2(1'b0, 1'b1, 8'd1);
    dir2(1'b0, 1'b0, 8'd0);
    dir2(1'b0, 1'b0, 8'd0);

    // Back-to-back tokens: b on cycles 0..3, off at 4
    dir2(1'b1, 1'b1, 8'd0);
    dir2(1'b1, 1'b1, 8'd1);
    dir2(1'b0, 1'b1, 8'd2);
    dir2(1'b0, 1'b1, 8'd1);
    dir2(1'b0, 1'b0, 8'd0);

    // MULT=3: tokens at 0 and 4 -> b on 0..2 and 4..6
    dir3(1'b1, 1'b1, 8'd0);
    dir3(1'b0, 1'b1, 8'd2);
    dir3(1'b0, 1'b1, 8'd1);
    dir3(1'b0, 1'b0, 8'd0);
    dir3(1'b1, 1'b1, 8'd0);
    dir3(1'b0, 1'b1, 8'd2);
    dir3(1'b0, 1'b1, 8'd1);
    dir3(1'b0, 1'b0, 8'd0);
    dir3(1'b0, 1'b0, 8'd0);

    // Random stream, token density kept low enough never to saturate
    @(posedge clk);
    #1;
    if2.a  = 1'b0;
    a_cnt  = 0;
    b_cnt  = 0;
    cnt_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step2($urandom_range(0, 2) == 0);
    end
    while (m2_pend != 0) step2(1'b0);
    step2(1'b0);
    @(negedge clk);
    #1;
    cnt_en = 1'b0;
    check("random b count == 2*a count", b_cnt, 2 * a_cnt);
    check("random overflow stays 0", {31'd0, if2.overflow}, 32'd0);

    // Saturation: a held for 260 cycles
    for (int i = 0; i < 260; i++) step2(1'b1);
    @(posedge clk);
    #1;
    if2.a = 1'b1;
    #1;
    check("saturated pending", {24'd0, if2.pending}, 32'd255);
    check("saturated overflow", {31'd0, if2.overflow}, 32'd1);

    // Asynchronous reset while saturated and a high
    #1;
    rst = 1'b0;
    #1;
    check("async reset clears b/ovf/pend", {22'd0, if2.b, if2.overflow, if2.pending}, 32'd0);
    @(posedge clk);
    #1;
    check("held reset keeps b/ovf/pend", {22'd0, if2.b, if2.overflow, if2.pending}, 32'd0);
    if2.a = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();

    // Mid-burst reset with pending=5
    for (int i = 0; i < 5; i++) step2(1'b1);
    @(posedge clk);
    #1;
    if2.a = 1'b0;
    check("pending before mid-burst reset", {24'd0, if2.pending}, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("mid-burst reset b/ovf/pend", {22'd0, if2.b, if2.overflow, if2.pending}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive2(1'b0);
    for (int i = 0; i < 3; i++) step2(1'b0);

    // A token present at the first edge after release is counted
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive2(1'b1);
    for (int i = 0; i < 3; i++) step2(1'b0);

    // Let the monitors consume the tail of the queues
    repeat (3) @(negedge clk);
    #1;
    check("dut2 expected queue drained", exp2_q.size(), 32'd0);
    check("dut3 expected queue drained", exp3_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
